// File: rtl/prog_loader_pkg.sv
// ---------------------------------------------------------------------------
// prog_loader_pkg
// Shared definitions for the program loader. It provides the default
// parameter widths, the 2-bit FSM state encoding and the state enum built
// from that encoding.
// ---------------------------------------------------------------------------
package prog_loader_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// This interface bundles the program-word stream, the instruction-memory
// write port and the loader's FSM state.
//
// Stream handshake: a beat transfers on a rising clock edge when s_valid and
// s_ready are both high in the same cycle. The source holds s_data and
// s_last stable while s_valid is high and s_ready is low. s_ready does not
// depend on s_valid.
//
//   s_valid   source -> loader  word present
//   s_data    source -> loader  program word
//   s_last    source -> loader  final word of the program
//   s_ready   loader -> source  loader accepts a word this cycle
//   im_we     loader -> memory  write strobe, same cycle as the accepted beat
//   im_addr   loader -> memory  write address
//   im_wdata  loader -> memory  write data
//   fsm_state loader -> observer current loader state (ST_* encoding)
// ---------------------------------------------------------------------------
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;
  logic [1:0]        fsm_state;

  // Loader side
  modport slave (
    input  s_valid, s_data, s_last,
    output s_ready, im_we, im_addr, im_wdata, fsm_state
  );

  // Program source / memory / observer side
  modport master (
    output s_valid, s_data, s_last,
    input  s_ready, im_we, im_addr, im_wdata, fsm_state
  );

endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// This block loads a program into instruction memory and then releases a
// processor core for a fixed number of cycles.
//
// Sequence: IDLE -> (start) LOAD -> (last word) RUN -> (run_len cycles or
// abort) DONE -> (start) LOAD ...
// If the program overflows the memory, LOAD goes straight to DONE with err
// set, and the core is never released.
//
// Ports
//   CLK, RST    clock (rising edge), asynchronous active-high reset
//   start       pulse; begins a load from IDLE or DONE, samples run_len
//   abort       forces DONE from LOAD or RUN
//   run_len     core run cycles; 0 = run until abort
//   bus         stream in, instruction-memory write out, FSM state out
//   core_rst    core reset, released only in RUN
//   running     high in RUN
//   done        high in DONE
//   err         program exceeded memory depth
//   load_count  words written by the last load
// ---------------------------------------------------------------------------
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic              abort,
  input  logic [CNT_W-1:0]  run_len,
  prog_loader_if.slave      bus,
  output logic              core_rst,
  output logic              running,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_count
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;  // DEPTH-1

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   load_count_q, load_count_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  run_len_q, run_len_d;

  logic accept;
  logic run_expired;

  assign accept = (state_q == S_LOAD) && bus.s_valid;

  // The counter wraps modulo 2**CNT_W. run_len = 0 never matches, so the
  // core runs freely until abort.
  assign run_expired = (run_len_q != '0) && (cnt_q == run_len_q - CNT_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      load_count_q <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      run_len_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      load_count_q <= load_count_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      run_len_q    <= run_len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    load_count_d = load_count_q;
    err_d        = err_q;
    cnt_d        = cnt_q;
    run_len_d    = run_len_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          run_len_d    = run_len;
          wr_ptr_d     = '0;
          load_count_d = '0;
          err_d        = 1'b0;
          cnt_d        = '0;
        end
      end

      S_LOAD: begin
        // s_ready is unconditionally high here, so a beat presented together
        // with abort is still written and counted. Abort only overrides where
        // the FSM goes next.
        if (accept) begin
          wr_ptr_d     = wr_ptr_q + 1'b1;
          load_count_d = load_count_q + 1'b1;
        end
        if (abort) begin
          state_d = S_DONE;
        end else if (accept && bus.s_last) begin
          state_d = S_RUN;
        end else if (accept && (wr_ptr_q == LAST_ADDR)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end

      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (abort || run_expired) begin
          state_d = S_DONE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // The write port is zero-latency and gated by acceptance, so address and
  // data sit at 0 whenever no write is happening.
  assign bus.s_ready   = (state_q == S_LOAD);
  assign bus.im_we     = accept;
  assign bus.im_addr   = accept ? wr_ptr_q : '0;
  assign bus.im_wdata  = accept ? bus.s_data : '0;
  assign bus.fsm_state = state_q;

  assign core_rst   = (state_q != S_RUN);
  assign running    = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign load_count = load_count_q;

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning instruction-memory address width (DEPTH = 2**ADDR_W = 32 words).
REQ-003 SHALL have parameter CNT_W, default 16, meaning run-cycle counter width.
REQ-004 SHALL have one clock and an asynchronous, active-high reset; the clock port is CLK and the reset port is RST.
REQ-005 SHALL have these ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  asynchronous active-high reset
- start  in  1  begin load sequence (pulse)
- abort  in  1  force DONE from any non-IDLE state
- run_len  in  CNT_W  cycles to release core; sampled at start
- s_valid  in  1  program word valid
- s_data  in  DATA_W  program word
- s_last  in  1  final program word
- s_ready  out  1  loader accepts word
- im_we  out  1  instruction-memory write enable
- im_addr  out  ADDR_W  instruction-memory write address
- im_wdata  out  DATA_W  instruction-memory write data
- core_rst  out  1  reset to processor core, active-high
- running  out  1  core released
- done  out  1  sequence finished
- err  out  1  program overflowed DEPTH
- load_count  out  ADDR_W+1  words written in last load

Function
REQ-006 SHALL implement states IDLE, LOAD, RUN, DONE in a registered FSM.
REQ-007 SHALL in IDLE drive core_rst=1, s_ready=0; start -> LOAD, latch run_len, clear wr_ptr, load_count, err, cycle counter.
REQ-008 SHALL in LOAD drive s_ready=1, core_rst=1; a beat is accepted when s_valid & s_ready.
REQ-009 SHALL on an accepted beat drive im_we=1, im_addr=wr_ptr, im_wdata=s_data combinationally in that same cycle (zero latency), then increment wr_ptr and load_count.
REQ-010 SHALL drive im_we=0 whenever no beat is accepted.
REQ-011 SHALL on an accepted beat with s_last=1 transition LOAD -> RUN.
REQ-012 SHALL on an accepted beat at wr_ptr=DEPTH-1 with s_last=0 write the word, set err=1, and transition LOAD -> DONE (core never released).
REQ-013 SHALL in RUN drive core_rst=0, running=1, s_ready=0; cycle counter increments each cycle from 0.
REQ-014 SHALL transition RUN -> DONE in the cycle the counter equals latched run_len-1; run_len=0 SHALL mean free-run until abort.
REQ-015 SHALL in DONE drive core_rst=1, done=1, running=0; start -> LOAD (re-latch run_len, clear err and counters).
REQ-016 SHALL on abort in LOAD or RUN transition to DONE next edge; abort has priority over s_last and counter expiry in the same cycle; abort in IDLE/DONE is ignored.
REQ-017 SHALL ignore start outside IDLE and DONE.
REQ-018 SHALL hold load_count, err stable in DONE until next start.
REQ-019 SHALL count cycles modulo 2**CNT_W without side effects when run_len=0.

Reset
REQ-020 SHALL on RST=1 asynchronously enter IDLE, with core_rst=1, s_ready=0, im_we=0, im_addr=0, im_wdata=0, running=0, done=0, err=0, load_count=0, counters 0.
REQ-021 SHALL when RST asserts mid-LOAD or mid-RUN abandon the sequence with no further im_we pulses.

Structure
REQ-022 SHALL place FSM state encoding (2-bit localparams) and default widths in a shared package prog_loader_pkg.
REQ-023 SHALL be a single module; no sub-module is required; the cycle counter stays inline.

Verification
REQ-024 SHALL cover: start, run_len=10, 4 beats 0x20080005,0x20090007,0x01095020,0xAC0A0000 (last on 4th) -> im_we on 4 cycles, addr 0..3, load_count=4, core_rst low exactly 10 cycles, then done=1.
REQ-025 SHALL cover: s_valid gaps (valid on alternate cycles) -> only valid cycles write, addresses contiguous 0..N-1.
REQ-026 SHALL cover: 32 beats, none with s_last -> 32 writes, err=1, done=1, core_rst never 0.
REQ-027 SHALL cover: abort in RUN cycle 3 with run_len=100 -> DONE next edge, core_rst=1.
REQ-028 SHALL cover: RST asserted mid-LOAD after 2 beats -> immediate IDLE, all outputs at reset values, no further writes.
REQ-029 SHALL cover: restart from DONE with run_len=0 -> RUN persists 300 cycles until abort, counter wraps without leaving RUN when CNT_W=8.
